// File: rtl/gcd_pkg.sv
// Shared types, defaults and helpers for the GCD request arbiter.
package gcd_pkg;

  localparam int GCD_WIDTH   = 4;
  localparam int GCD_NUM_REQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } gcd_state_e;

  function automatic int gcd_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/gcd_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  int pos_s;

  // Scan N slots starting at ptr; the first hit wins.
  always_comb begin
    grant = {N{1'b0}};
    idx   = {IDX_W{1'b0}};
    any   = 1'b0;
    pos_s = 0;
    for (int k = 0; k < N; k++) begin
      pos_s = (int'(ptr) + k) % N;
      if (!any && req[pos_s]) begin
        any          = 1'b1;
        grant[pos_s] = 1'b1;
        idx          = IDX_W'(pos_s);
      end else begin
      end
    end
  end

endmodule

// File: rtl/gcd_arbiter.sv
// Shares one subtract-loop GCD engine between NUM_REQ requesters, round-robin.
// Optional watchdog in WAIT enabled by the macro GCD_TIMEOUT_EN.
module gcd_arbiter
  import gcd_pkg::*;
#(
  parameter int NUM_REQ = GCD_NUM_REQ,
  parameter int WIDTH   = GCD_WIDTH,
  parameter int ID_W    = gcd_clog2(NUM_REQ)
`ifdef GCD_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 64
`endif
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_x,
  input  logic [NUM_REQ*WIDTH-1:0] req_y,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     rsp_valid,
  output logic [ID_W-1:0]          rsp_id,
  output logic [WIDTH-1:0]         rsp_d,
  output logic                     rsp_err,
  output logic                     eng_go,
  output logic [WIDTH-1:0]         eng_x,
  output logic [WIDTH-1:0]         eng_y,
  output logic                     eng_abort,
  input  logic                     eng_done,
  input  logic [WIDTH-1:0]         eng_d
);

  gcd_state_e         state_r, state_s;
  logic [ID_W-1:0]    rr_ptr_r, id_r, rsp_id_r;
  logic [WIDTH-1:0]   x_r, y_r, rsp_d_r;
  logic               rsp_err_r;
  logic [NUM_REQ-1:0] pick_grant_s;
  logic [ID_W-1:0]    pick_idx_s;
  logic               pick_any_s;
  logic [WIDTH-1:0]   sel_x_s, sel_y_s;
  logic               zero_s;
  logic               timeout_s;

  rr_picker #(.N(NUM_REQ), .IDX_W(ID_W)) u_picker (
    .req   (req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  assign sel_x_s = req_x[int'(pick_idx_s)*WIDTH +: WIDTH];
  assign sel_y_s = req_y[int'(pick_idx_s)*WIDTH +: WIDTH];
  // The engine never terminates on a zero operand, so those jobs bypass it.
  assign zero_s  = (sel_x_s == {WIDTH{1'b0}}) || (sel_y_s == {WIDTH{1'b0}});

`ifdef GCD_TIMEOUT_EN
  localparam int CNT_W = gcd_clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wd_cnt_r;

  // Watchdog counts WAIT cycles; it sits at zero everywhere else.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r != ST_WAIT) begin
      wd_cnt_r <= {CNT_W{1'b0}};
    end else begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end
  end

  // Fires on the TIMEOUT_CYCLES-th WAIT cycle; a coincident done wins.
  assign timeout_s = (state_r == ST_WAIT) && !eng_done &&
                     (wd_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_s = 1'b0;
`endif

  // State register.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (pick_any_s) begin
          state_s = zero_s ? ST_RESP : ST_ISSUE;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ISSUE: state_s = ST_WAIT;
      ST_WAIT: begin
        if (eng_done || timeout_s) begin
          state_s = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // Operand/id latches, response registers and round-robin pointer.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      rr_ptr_r  <= {ID_W{1'b0}};
      id_r      <= {ID_W{1'b0}};
      x_r       <= {WIDTH{1'b0}};
      y_r       <= {WIDTH{1'b0}};
      rsp_id_r  <= {ID_W{1'b0}};
      rsp_d_r   <= {WIDTH{1'b0}};
      rsp_err_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pick_any_s) begin
            x_r  <= sel_x_s;
            y_r  <= sel_y_s;
            id_r <= pick_idx_s;
            if (zero_s) begin
              rsp_id_r  <= pick_idx_s;
              rsp_d_r   <= sel_x_s | sel_y_s;
              rsp_err_r <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (eng_done) begin
            rsp_id_r  <= id_r;
            rsp_d_r   <= eng_d;
            rsp_err_r <= 1'b0;
          end else if (timeout_s) begin
            rsp_id_r  <= id_r;
            rsp_d_r   <= {WIDTH{1'b0}};
            rsp_err_r <= 1'b1;
          end
        end
        ST_RESP: begin
          rr_ptr_r <= (id_r == ID_W'(NUM_REQ - 1)) ? {ID_W{1'b0}} : id_r + ID_W'(1);
        end
        default: begin
        end
      endcase
    end
  end

  // Grant is gated by RESET so every output reads zero while reset is held.
  assign req_ready = (state_r == ST_IDLE && RESET) ? pick_grant_s : {NUM_REQ{1'b0}};
  assign rsp_valid = (state_r == ST_RESP);
  assign rsp_id    = rsp_id_r;
  assign rsp_d     = rsp_d_r;
  assign rsp_err   = rsp_err_r;
  assign eng_go    = (state_r == ST_ISSUE);
  assign eng_x     = x_r;
  assign eng_y     = y_r;
  assign eng_abort = timeout_s;

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural engine of programmable latency.
module tb_gcd_arbiter;

  logic        CLK;
  logic        RESET;
  logic [3:0]  req_valid;
  logic [15:0] req_x, req_y;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [3:0]  rsp_d;
  logic        rsp_err;
  logic        eng_go;
  logic [3:0]  eng_x, eng_y;
  logic        eng_abort;
  logic        eng_done;
  logic [3:0]  eng_d;

  int err_cnt = 0;
  int chk_cnt = 0;
  int cyc = 0;
  int go_cnt = 0;
  int rsp_cnt = 0;
  int abort_cnt = 0;
  int eng_lat = 5;
  int ecnt = 0;

  gcd_arbiter #(
    .NUM_REQ(4),
    .WIDTH(4)
`ifdef GCD_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_x(req_x), .req_y(req_y), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_d(rsp_d), .rsp_err(rsp_err),
    .eng_go(eng_go), .eng_x(eng_x), .eng_y(eng_y), .eng_abort(eng_abort),
    .eng_done(eng_done), .eng_d(eng_d)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [3:0] gcd_ref(input logic [3:0] a_in, input logic [3:0] b_in);
    logic [3:0] a, b;
    a = a_in;
    b = b_in;
    while (a != b) begin
      if (a > b) a = a - b;
      else b = b - a;
    end
    return a;
  endfunction

  // Engine model: done pulses eng_lat cycles after go (eng_lat=0: never).
  initial begin
    eng_done = 1'b0;
    eng_d = 4'd0;
    forever begin
      @(negedge CLK);
      eng_done = 1'b0;
      if (!RESET) ecnt = 0;
      else if (eng_go) ecnt = eng_lat;
      else if (ecnt > 0) begin
        ecnt = ecnt - 1;
        if (ecnt == 0) begin
          eng_done = 1'b1;
          eng_d = gcd_ref(eng_x, eng_y);
        end
      end
    end
  end

  // Event counters, sampled mid-low-phase after the main thread.
  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (eng_go) go_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (eng_abort) abort_cnt++;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
    cyc++;
  endtask

  task automatic wait_grant(input string tag, input logic [3:0] exp, output int t);
    int n;
    n = 0;
    #1;
    while (req_ready == 4'b0000 && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_grant"}, 32'(req_ready), 32'(exp));
    t = cyc;
  endtask

  task automatic wait_rsp(input string tag, input int id, input logic [3:0] d,
                          input logic err, output int t);
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"}, 32'(rsp_id), 32'(id));
    check({tag, "_d"}, 32'(rsp_d), 32'(d));
    check({tag, "_err"}, 32'(rsp_err), 32'(err));
    t = cyc;
  endtask

  // One job: grant at T, eng_go at T+1 (none for zero bypass), response at T+lat.
  task automatic run_job(input string tag, input int idx, input logic [3:0] x,
                         input logic [3:0] y, input logic [3:0] d, input int lat);
    int t0, t1, g0;
    req_x[idx*4 +: 4] = x;
    req_y[idx*4 +: 4] = y;
    req_valid[idx] = 1'b1;
    g0 = go_cnt;
    wait_grant(tag, 4'b0001 << idx, t0);
    tick();
    req_valid[idx] = 1'b0;
    check({tag, "_go"}, 32'(eng_go), (lat > 1) ? 32'd1 : 32'd0);
    check({tag, "_engx"}, 32'(eng_x), 32'(x));
    check({tag, "_engy"}, 32'(eng_y), 32'(y));
    wait_rsp(tag, idx, d, 1'b0, t1);
    check({tag, "_lat"}, 32'(t1 - t0), 32'(lat));
    check({tag, "_gocnt"}, 32'(go_cnt - g0), (lat > 1) ? 32'd1 : 32'd0);
  endtask

  initial begin
    int t0, t1, ta, rc, n, exp_abort;
    exp_abort = 0;
    RESET = 1'b0;
    req_valid = 4'b0000;
    req_x = 16'd0;
    req_y = 16'd0;
    repeat (3) tick();
    check("por_ready", 32'(req_ready), 32'd0);
    check("por_rsp_valid", 32'(rsp_valid), 32'd0);
    check("por_eng_go", 32'(eng_go), 32'd0);
    check("por_rsp_d", 32'(rsp_d), 32'd0);
    check("por_abort", 32'(eng_abort), 32'd0);
    RESET = 1'b1;

    // All request after reset: requester 0 first; gcd(6,4)=2.
    req_x = {4{4'd6}};
    req_y = {4{4'd4}};
    req_valid = 4'b1111;
    run_job("first", 0, 4'd6, 4'd4, 4'd2, 7);
    req_valid = 4'b0000;

    // Single job from requester 1, engine latency 5.
    run_job("single", 1, 4'd12, 4'd8, 4'd4, 7);

    // Reset mid-WAIT: outputs clear at once, no response, pointer back to 0.
    req_x[7:4] = 4'd12;
    req_y[7:4] = 4'd8;
    req_valid = 4'b0010;
    wait_grant("mid", 4'b0010, t0);
    tick();
    req_valid = 4'b0000;
    tick();
    tick();
    rc = rsp_cnt;
    RESET = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check("rst_rsp_d", 32'(rsp_d), 32'd0);
    check("rst_eng_x", 32'(eng_x), 32'd0);
    check("rst_eng_y", 32'(eng_y), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (3) tick();
    check("rst_ready_held", 32'(req_ready), 32'd0);
    RESET = 1'b1;
    req_valid = 4'b0000;
    repeat (10) tick();
    check("rst_no_rsp", 32'(rsp_cnt - rc), 32'd0);

    // Round robin from pointer 0 over requesters 0, 2, 3; 0 re-raised early.
    req_x = {4'd9, 4'd9, 4'd0, 4'd9};
    req_y = {4'd6, 4'd6, 4'd0, 4'd6};
    req_valid = 4'b1101;
    run_job("rr0", 0, 4'd9, 4'd6, 4'd3, 7);
    req_x[3:0] = 4'd15;
    req_y[3:0] = 4'd10;
    req_valid[0] = 1'b1;
    run_job("rr2", 2, 4'd9, 4'd6, 4'd3, 7);
    run_job("rr3", 3, 4'd9, 4'd6, 4'd3, 7);
    run_job("rr0b", 0, 4'd15, 4'd10, 4'd5, 7);

    // Zero-operand bypass.
    run_job("byp_0_9", 2, 4'd0, 4'd9, 4'd9, 1);
    run_job("byp_7_0", 3, 4'd7, 4'd0, 4'd7, 1);
    run_job("byp_0_0", 0, 4'd0, 4'd0, 4'd0, 1);

`ifdef GCD_TIMEOUT_EN
    // Engine never answers: abort on the 8th WAIT cycle, error response next.
    exp_abort = 1;
    eng_lat = 0;
    req_x[7:4] = 4'd12;
    req_y[7:4] = 4'd8;
    req_valid = 4'b0010;
    wait_grant("to", 4'b0010, t0);
    tick();
    req_valid = 4'b0000;
    n = 0;
    while (!eng_abort && n < 40) begin
      tick();
      n++;
    end
    ta = cyc;
    check("to_abort", 32'(eng_abort), 32'd1);
    check("to_abort_at", 32'(ta - t0), 32'd9);
    tick();
    wait_rsp("to_rsp", 1, 4'd0, 1'b1, t1);
    check("to_rsp_at", 32'(t1 - t0), 32'd10);
    // Done on the limit cycle wins.
    eng_lat = 8;
    run_job("to_edge", 2, 4'd9, 4'd6, 4'd3, 10);
`endif

    tick();
    check("abort_cnt", 32'(abort_cnt), 32'(exp_abort));

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
